// File: rtl/latch_write_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// latch_write_ctrl_pkg
// Shared definitions for the latch write controller:
//   - state_e     : controller FSM states
//   - CNT_W       : width of the phase down-counter (holds up to 255)
//   - *_MIN/_MAX  : legal parameter ranges, checked at elaboration
//   - cyc_to_load : converts a phase length in cycles to a counter reload
// ----------------------------------------------------------------------------
package latch_write_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_OPEN  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int CNT_W     = 8;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int SETUP_MIN = 0;
  localparam int SETUP_MAX = 255;
  localparam int OPEN_MIN  = 1;
  localparam int OPEN_MAX  = 255;
  localparam int HOLD_MIN  = 0;
  localparam int HOLD_MAX  = 255;

  // A phase of n cycles ends on the edge where the counter reads zero, so
  // the reload value is n-1. Zero-length phases are never entered; they
  // still map to 0 so the function is total.
  function automatic logic [CNT_W-1:0] cyc_to_load(input int n);
    if (n <= 0) begin
      return '0;
    end
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/latch_write_ctrl_cnt.sv
// ----------------------------------------------------------------------------
// latch_write_ctrl_cnt
// Loadable phase down-counter. Reload has priority over counting; the
// counter stops at zero and reports zero through o_zero.
// Ports:
//   C          in   clock (rising edge)
//   R          in   synchronous active-high reset, forces count to 0
//   i_load     in   reload strobe
//   i_load_val in   CNT_W reload value
//   o_zero     out  count is zero
// ----------------------------------------------------------------------------
module latch_write_ctrl_cnt
  import latch_write_ctrl_pkg::*;
(
  input  logic             C,
  input  logic             R,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge C) begin
    if (R) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/latch_write_ctrl.sv
// ----------------------------------------------------------------------------
// latch_write_ctrl
// Drives the D and G inputs of a bank of transparent latches. A write
// accepted on the IN_VALID/IN_READY handshake loads D, waits SETUP_CYC
// cycles with G low, opens the gate for OPEN_CYC cycles, then keeps D
// stable for HOLD_CYC cycles with G low before returning to IDLE and
// pulsing DONE. D and G are registered outputs.
//
// Parameters:
//   WIDTH (1..64), SETUP_CYC (0..255), OPEN_CYC (1..255), HOLD_CYC (0..255)
// Ports:
//   C         in   clock, rising edge
//   R         in   synchronous active-high reset
//   IN_VALID  in   write request valid
//   IN_READY  out  controller idle, can accept a write
//   IN_DATA   in   [WIDTH] write data
//   D         out  [WIDTH] data to latch D inputs
//   G         out  gate to latch G inputs
//   BUSY      out  high whenever not IDLE
//   DONE      out  one-cycle pulse on return to IDLE after a write
// Optional (macro LATCH_WRITE_CTRL_CHECK_EN):
//   Q_FB      in   [WIDTH] latch Q readback, compared with D on the last
//                  OPEN cycle
//   ERR       out  sticky mismatch flag, cleared only by R
// ----------------------------------------------------------------------------
module latch_write_ctrl
  import latch_write_ctrl_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic             C,
  input  logic             R,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic [WIDTH-1:0] D,
  output logic             G,
  output logic             BUSY,
`ifdef LATCH_WRITE_CTRL_CHECK_EN
  input  logic [WIDTH-1:0] Q_FB,
  output logic             ERR,
`endif
  output logic             DONE
);

  // Elaboration-time parameter range checks
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("latch_write_ctrl: WIDTH out of range");
  end
  if (SETUP_CYC < SETUP_MIN || SETUP_CYC > SETUP_MAX) begin : g_bad_setup
    $error("latch_write_ctrl: SETUP_CYC out of range");
  end
  if (OPEN_CYC < OPEN_MIN || OPEN_CYC > OPEN_MAX) begin : g_bad_open
    $error("latch_write_ctrl: OPEN_CYC out of range");
  end
  if (HOLD_CYC < HOLD_MIN || HOLD_CYC > HOLD_MAX) begin : g_bad_hold
    $error("latch_write_ctrl: HOLD_CYC out of range");
  end

  localparam logic [CNT_W-1:0] SETUP_LD = cyc_to_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] OPEN_LD  = cyc_to_load(OPEN_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD  = cyc_to_load(HOLD_CYC);

  state_e           r_state;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_g;
  logic [WIDTH-1:0] r_d;

  state_e           w_state_nxt;
  logic             w_hs;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_zero;

  assign w_hs = r_ready & IN_VALID;

  // Next state and counter reload. Every state change reloads the counter
  // with the length of the phase being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_load  = 1'b0;
    w_cnt_val   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          w_cnt_load = 1'b1;
          if (SETUP_CYC > 0) begin
            w_state_nxt = ST_SETUP;
            w_cnt_val   = SETUP_LD;
          end else begin
            w_state_nxt = ST_OPEN;
            w_cnt_val   = OPEN_LD;
          end
        end
      end
      ST_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_OPEN;
          w_cnt_load  = 1'b1;
          w_cnt_val   = OPEN_LD;
        end
      end
      ST_OPEN: begin
        if (w_cnt_zero) begin
          w_cnt_load = 1'b1;
          if (HOLD_CYC > 0) begin
            w_state_nxt = ST_HOLD;
            w_cnt_val   = HOLD_LD;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_val   = '0;
          end
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
          w_cnt_load  = 1'b1;
          w_cnt_val   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_load  = 1'b1;
        w_cnt_val   = '0;
      end
    endcase
  end

  latch_write_ctrl_cnt u_cnt (
    .C          (C),
    .R          (R),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_zero     (w_cnt_zero)
  );

  // State and registered outputs. Outputs are decoded from the next state
  // so they line up with the state register; G never comes from the counter.
  always_ff @(posedge C) begin
    if (R) begin
      r_state <= ST_IDLE;
      r_d     <= '0;
      r_g     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_g     <= (w_state_nxt == ST_OPEN);
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_ready <= (w_state_nxt == ST_IDLE);
      r_done  <= (w_state_nxt == ST_IDLE) && (r_state != ST_IDLE);
      if (r_state == ST_IDLE && w_hs) begin
        r_d <= IN_DATA;
      end
    end
  end

`ifdef LATCH_WRITE_CTRL_CHECK_EN
  logic r_err;

  // Q_FB is sampled at the edge that closes the gate, when the latch has
  // been transparent for the full open window.
  always_ff @(posedge C) begin
    if (R) begin
      r_err <= 1'b0;
    end else if (r_state == ST_OPEN && w_cnt_zero && Q_FB != r_d) begin
      r_err <= 1'b1;
    end
  end

  assign ERR = r_err;
`endif

  assign IN_READY = r_ready;
  assign D        = r_d;
  assign G        = r_g;
  assign BUSY     = r_busy;
  assign DONE     = r_done;

endmodule

// File: tb/tb_latch_write_ctrl.sv
module tb_latch_write_ctrl;

  logic       C = 1'b0;
  logic [1:0] rr = 2'b11;
  logic [1:0] vv = 2'b00;
  logic [3:0] din [2];
  logic [3:0] dout [2];
  logic [1:0] rdy, g, busy, done;
`ifdef LATCH_WRITE_CTRL_CHECK_EN
  logic [3:0] qfb [2];
  logic [1:0] err;
`endif

  int total = 0;
  int bad   = 0;

  // reference model: elapsed edges since the accepting handshake
  int         ps [2] = '{1, 0};
  int         po [2] = '{2, 1};
  int         ph [2] = '{1, 0};
  int         me [2];
  bit         mact [2];
  logic [3:0] md [2];
  bit         merr [2];

  always #5 C = ~C;

  latch_write_ctrl #(.WIDTH(4), .SETUP_CYC(1), .OPEN_CYC(2), .HOLD_CYC(1)) dut0 (
    .C(C), .R(rr[0]), .IN_VALID(vv[0]), .IN_READY(rdy[0]), .IN_DATA(din[0]),
    .D(dout[0]), .G(g[0]), .BUSY(busy[0]),
`ifdef LATCH_WRITE_CTRL_CHECK_EN
    .Q_FB(qfb[0]), .ERR(err[0]),
`endif
    .DONE(done[0])
  );

  latch_write_ctrl #(.WIDTH(4), .SETUP_CYC(0), .OPEN_CYC(1), .HOLD_CYC(0)) dut1 (
    .C(C), .R(rr[1]), .IN_VALID(vv[1]), .IN_READY(rdy[1]), .IN_DATA(din[1]),
    .D(dout[1]), .G(g[1]), .BUSY(busy[1]),
`ifdef LATCH_WRITE_CTRL_CHECK_EN
    .Q_FB(qfb[1]), .ERR(err[1]),
`endif
    .DONE(done[1])
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_edge(input int i);
    int t_end;
    bit ready;
    t_end = ps[i] + po[i] + ph[i];
    if (rr[i]) begin
      mact[i] = 0;
      md[i]   = 4'h0;
      merr[i] = 0;
    end else begin
`ifdef LATCH_WRITE_CTRL_CHECK_EN
      if (mact[i] && me[i] == ps[i] + po[i] - 1 && qfb[i] !== md[i]) merr[i] = 1;
`endif
      ready = !mact[i] || me[i] >= t_end;
      if (ready && vv[i]) begin
        mact[i] = 1;
        me[i]   = 0;
        md[i]   = din[i];
      end else if (mact[i]) begin
        me[i]++;
        if (me[i] > t_end) mact[i] = 0;
      end
    end
  endtask

  task automatic check_inst(input int i);
    int  t_end;
    bit  eg, eb, ed, er;
    t_end = ps[i] + po[i] + ph[i];
    if (mact[i]) begin
      eg = (me[i] >= ps[i]) && (me[i] < ps[i] + po[i]);
      eb = me[i] < t_end;
      ed = me[i] == t_end;
      er = me[i] >= t_end;
    end else begin
      eg = 0; eb = 0; ed = 0; er = 1;
    end
    chk($sformatf("G%0d", i),     8'(g[i]),    8'(eg));
    chk($sformatf("BUSY%0d", i),  8'(busy[i]), 8'(eb));
    chk($sformatf("DONE%0d", i),  8'(done[i]), 8'(ed));
    chk($sformatf("READY%0d", i), 8'(rdy[i]),  8'(er));
    chk($sformatf("D%0d", i),     8'(dout[i]), 8'(md[i]));
`ifdef LATCH_WRITE_CTRL_CHECK_EN
    chk($sformatf("ERR%0d", i),   8'(err[i]),  8'(merr[i]));
`endif
  endtask

  task automatic tick();
    @(posedge C);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) check_inst(i);
  endtask

  initial begin
    din[0] = 4'h0; din[1] = 4'h0;
`ifdef LATCH_WRITE_CTRL_CHECK_EN
    qfb[0] = 4'h0; qfb[1] = 4'h0;
`endif
    for (int i = 0; i < 2; i++) begin
      me[i] = 0; mact[i] = 0; md[i] = 4'h0; merr[i] = 0;
    end

    // reset, with IN_VALID high to confirm it is ignored under reset
    rr = 2'b11; vv = 2'b11; din[0] = 4'h9; din[1] = 4'h9;
    tick(); tick();
    chk("reset_ready0", 8'(rdy[0]), 8'h1);
    chk("reset_d0", 8'(dout[0]), 8'h0);
    rr = 2'b00; vv = 2'b00;
    tick();

    // S=1,O=2,H=1 write 0xA
    vv[0] = 1; din[0] = 4'hA;
    tick();
    chk("w0_d_e0", 8'(dout[0]), 8'hA);
    vv[0] = 0;
    tick(); chk("w0_g_e1", 8'(g[0]), 8'h1);
    tick(); chk("w0_g_e2", 8'(g[0]), 8'h1);
    tick(); chk("w0_g_e3", 8'(g[0]), 8'h0);
    tick(); chk("w0_done_e4", 8'(done[0]), 8'h1);
    tick(); chk("w0_done_e5", 8'(done[0]), 8'h0);

    // S=0,O=1,H=0 back-to-back 0x1 then 0x2 with IN_VALID held
    vv[1] = 1; din[1] = 4'h1;
    tick(); chk("b2b_g_e0", 8'(g[1]), 8'h1);
    din[1] = 4'h2;
    tick(); chk("b2b_d_e1", 8'(dout[1]), 8'h1);
    tick(); chk("b2b_d_e2", 8'(dout[1]), 8'h2);
    chk("b2b_g_e2", 8'(g[1]), 8'h1);
    vv[1] = 0;
    tick(); tick();

    // reset at the first OPEN cycle of write 0x5
    vv[0] = 1; din[0] = 4'h5;
    tick(); vv[0] = 0;
    tick(); chk("abort_g_open", 8'(g[0]), 8'h1);
    rr[0] = 1;
    tick();
    chk("abort_g", 8'(g[0]), 8'h0);
    chk("abort_d", 8'(dout[0]), 8'h0);
    chk("abort_busy", 8'(busy[0]), 8'h0);
    rr[0] = 0;
    tick();
    chk("abort_ready", 8'(rdy[0]), 8'h1);
    chk("abort_done", 8'(done[0]), 8'h0);
    tick();

    // IN_DATA toggling while busy must not reach D
    vv[0] = 1; din[0] = 4'h3;
    tick(); vv[0] = 0;
    for (int k = 0; k < 4; k++) begin
      din[0] = (k % 2 == 0) ? 4'hC : 4'h3;
      tick();
      chk("hold_d", 8'(dout[0]), 8'h3);
    end
    tick();

`ifdef LATCH_WRITE_CTRL_CHECK_EN
    // readback stuck at 0 while writing 0xF, then a correct write
    qfb[0] = 4'h0; vv[0] = 1; din[0] = 4'hF;
    tick(); vv[0] = 0;
    tick(); tick(); tick();
    chk("err_set", 8'(err[0]), 8'h1);
    tick();
    qfb[0] = 4'hF; vv[0] = 1;
    tick(); vv[0] = 0;
    for (int k = 0; k < 4; k++) tick();
    chk("err_sticky", 8'(err[0]), 8'h1);
    rr[0] = 1;
    tick();
    chk("err_clear", 8'(err[0]), 8'h0);
    rr[0] = 0;
    tick();
`endif

    // randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        rr[i]  = ($urandom_range(0, 39) == 0);
        vv[i]  = 1'($urandom_range(0, 1));
        din[i] = 4'($urandom);
`ifdef LATCH_WRITE_CTRL_CHECK_EN
        qfb[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : md[i];
`endif
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/latch_write_ctrl.md
LATCH_WRITE_CTRL -- requirements
Module: latch_write_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 1, data width of the driven LATCH bank (1..64).
REQ-002 SHALL have parameter SETUP_CYC, default 1, number of D-stable cycles before G rises (0..255).
REQ-003 SHALL have parameter OPEN_CYC, default 1, number of cycles G is high (1..255).
REQ-004 SHALL have parameter HOLD_CYC, default 1, number of D-stable cycles after G falls (0..255).
REQ-005 SHALL have port C  input  1  clock; single clock domain, all logic on its rising edge.
REQ-006 SHALL have port R  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port IN_VALID  input  1  write request valid.
REQ-008 SHALL have port IN_READY  output  1  controller can accept a write.
REQ-009 SHALL have port IN_DATA  input  WIDTH  write data.
REQ-010 SHALL have port D  output  WIDTH  registered data to the LATCH D inputs.
REQ-011 SHALL have port G  output  1  registered gate to the LATCH G inputs.
REQ-012 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse at end of a write.

Function
REQ-014 SHALL implement an FSM with states IDLE, SETUP, OPEN and HOLD.
REQ-015 SHALL drive IN_READY high only in IDLE; a handshake occurs on an edge where IN_VALID and IN_READY are both high.
REQ-016 SHALL, on handshake at edge 0, load D with IN_DATA and enter SETUP, or enter OPEN directly if SETUP_CYC=0.
REQ-017 SHALL remain SETUP_CYC cycles in SETUP with G=0, then OPEN_CYC cycles in OPEN with G=1, then HOLD_CYC cycles in HOLD with G=0.
REQ-018 SHALL skip HOLD when HOLD_CYC=0, going OPEN->IDLE directly.
REQ-019 SHALL hold D constant from handshake until the next handshake; IN_DATA changes while busy are ignored.
REQ-020 SHALL assert DONE for exactly the first cycle after re-entering IDLE, i.e. after edge SETUP_CYC+OPEN_CYC+HOLD_CYC; IN_READY is high in that same cycle.
REQ-021 SHALL allow the next handshake at earliest edge SETUP_CYC+OPEN_CYC+HOLD_CYC+1, with no idle bubble beyond that.
REQ-022 SHALL use a single phase down-counter sized to hold 255, reloaded on every state entry; G is never combinationally derived from the counter.
REQ-023 SHALL reject out-of-range parameters at elaboration, including OPEN_CYC=0.

Reset
REQ-024 SHALL, while R is high at an edge, force state IDLE, D=0, G=0, DONE=0, BUSY=0 and counter=0, with IN_READY high in the cycle after reset releases.
REQ-025 SHALL, on reset mid-write (any state), drop G at that edge, abort the write, and not pulse DONE.
REQ-026 SHALL ignore IN_VALID on an edge where R is high.

Configuration
REQ-027 SHALL, when macro LATCH_WRITE_CTRL_CHECK_EN is defined, add input Q_FB[WIDTH] (latch Q readback) and output ERR (1 bit, reset 0).
REQ-028 SHALL, with the macro defined, compare Q_FB to D on the last OPEN cycle and set ERR sticky on mismatch; ERR clears only on R.
REQ-029 SHALL, without the macro, omit Q_FB and ERR ports and all compare logic, with functional behaviour otherwise identical.

Structure
REQ-030 SHALL place the state enum, counter-width constant (8) and parameter-range limits in package latch_write_ctrl_pkg.
REQ-031 SHALL factor the loadable down-counter into one sub-module, latch_write_ctrl_cnt; the FSM and output registers stay in the top.

Verification
REQ-032 SHALL cover S=1,O=2,H=1, WIDTH=4, write 0xA at edge 0 -> D=0xA after edge 0, G high after edges 1..2 and low after edge 3, DONE high only after edge 4.
REQ-033 SHALL cover S=0,O=1,H=0, back-to-back writes 0x1 then 0x2 with IN_VALID held -> G high one cycle per write, handshakes at edges 0 and 2, D=0x2 after edge 2.
REQ-034 SHALL cover R asserted at the first OPEN cycle of write 0x5 -> G=0, D=0 and BUSY=0 after that edge, no DONE pulse, IN_READY=1 next cycle.
REQ-035 SHALL cover IN_DATA toggled 0x3->0xC during SETUP/OPEN/HOLD after writing 0x3 -> D stays 0x3 throughout.
REQ-036 SHALL cover, with LATCH_WRITE_CTRL_CHECK_EN defined, Q_FB=0x0 while writing 0xF -> ERR=1 after the last OPEN edge and remaining 1 through a following correct write until R.
